// File: rtl/cu_mc.sv
// Multi-cycle control unit for the 16-bit accumulator CPU: fetch, decode,
// ALU/memory/stack handshakes with per-wait timeout, branch resolution and PC.
module cu_mc #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 10,
  parameter int OPC_W   = 6,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  output logic               instr_ready,
  output logic [PC_W-1:0]    pc_out,
  input  logic               fl_zero,
  input  logic               fl_negative,
  input  logic               fl_carry,
  input  logic               fl_overflow,
  input  logic [DATA_W-1:0]  reg_rdata,
  output logic [1:0]         reg_sel,
  output logic               reg_we,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               alu_enable,
  output logic [OPC_W-1:0]   alu_op,
  output logic [DATA_W-1:0]  term1,
  output logic [DATA_W-1:0]  term2,
  input  logic               alu_done,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               mem_re,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_done,
  output logic               push_req,
  output logic               pop_req,
  output logic [DATA_W-1:0]  push_data,
  input  logic               push_done,
  input  logic               pop_done,
  input  logic [DATA_W-1:0]  pop_out,
  output logic               branch,
  output logic               halted,
  output logic               error,
  output logic [2:0]         dbg_state
);

  localparam int FW    = INSTR_W - OPC_W - 1;
  localparam int EXT_W = (FW > PC_W) ? FW : PC_W;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [OPC_W-1:0] OP_ALU_LO = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_ALU_HI = OPC_W'(8'h0F);
  localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(8'h10);
  localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(8'h11);
  localparam logic [OPC_W-1:0] OP_BRZ    = OPC_W'(8'h12);
  localparam logic [OPC_W-1:0] OP_BRN    = OPC_W'(8'h13);
  localparam logic [OPC_W-1:0] OP_BRC    = OPC_W'(8'h14);
  localparam logic [OPC_W-1:0] OP_BRO    = OPC_W'(8'h15);
  localparam logic [OPC_W-1:0] OP_BRA    = OPC_W'(8'h16);
  localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(8'h17);
  localparam logic [OPC_W-1:0] OP_PUSH   = OPC_W'(8'h18);
  localparam logic [OPC_W-1:0] OP_POP    = OPC_W'(8'h19);
  localparam logic [OPC_W-1:0] OP_CALL   = OPC_W'(8'h1A);
  localparam logic [OPC_W-1:0] OP_RET    = OPC_W'(8'h1B);
  localparam logic [OPC_W-1:0] OP_HLT    = OPC_W'(8'h3F);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_ALU_WAIT, S_MEM_WAIT, S_STK_WAIT, S_RETIRE, S_HALT
  } state_t;

  // Handshakes: instr_valid/instr_ready transfer when both are high in FETCH.
  // Every request (alu_enable, mem_re/we, push_req/pop_req) is held high from
  // entry of its wait state until its done is seen or the timeout expires.

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      npc_q, npc_d;
  logic                 taken_q, taken_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [OPC_W-1:0]     opc;
  logic                 rsel;
  logic [FW-1:0]        field;
  logic [EXT_W-1:0]     off_ext;
  logic [EXT_W-1:0]     fld_zx;
  logic [PC_W-1:0]      pc_inc;
  logic [PC_W-1:0]      br_target;
  logic [PC_W-1:0]      jmp_target;
  logic                 timeout_hit;
  logic                 is_load;
  logic                 is_push_side;

  assign opc        = instr_q[INSTR_W-1 -: OPC_W];
  assign rsel       = instr_q[INSTR_W-OPC_W-1];
  assign field      = instr_q[FW-1:0];
  assign off_ext    = EXT_W'($signed(field));
  assign fld_zx     = EXT_W'(field);
  assign pc_inc     = pc_q + PC_W'(1);
  assign br_target  = pc_q + off_ext[PC_W-1:0];
  assign jmp_target = fld_zx[PC_W-1:0];
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign is_load      = (opc == OP_LOAD);
  assign is_push_side = (opc == OP_PUSH) || (opc == OP_CALL);

  assign pc_out    = pc_q;
  assign error     = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    npc_d       = npc_q;
    taken_d     = taken_q;
    instr_d     = instr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    instr_ready = 1'b0;
    reg_sel     = 2'd0;
    reg_we      = 1'b0;
    reg_wdata   = '0;
    alu_enable  = 1'b0;
    alu_op      = '0;
    term1       = '0;
    term2       = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    push_req    = 1'b0;
    pop_req     = 1'b0;
    push_data   = '0;
    branch      = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instruction;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Read the rsel register now; it is the ALU's term2 or the store/push data.
        reg_sel = {1'b0, rsel};
        data_d  = reg_rdata;
        npc_d   = pc_inc;
        taken_d = 1'b0;
        cnt_d   = '0;
        state_d = S_RETIRE;
        case (opc)
          OP_LOAD, OP_STORE: state_d = S_MEM_WAIT;
          OP_BRZ: if (fl_zero)     begin npc_d = br_target; taken_d = 1'b1; end
          OP_BRN: if (fl_negative) begin npc_d = br_target; taken_d = 1'b1; end
          OP_BRC: if (fl_carry)    begin npc_d = br_target; taken_d = 1'b1; end
          OP_BRO: if (fl_overflow) begin npc_d = br_target; taken_d = 1'b1; end
          OP_BRA: begin npc_d = br_target;  taken_d = 1'b1; end
          OP_JMP: begin npc_d = jmp_target; taken_d = 1'b1; end
          OP_PUSH, OP_POP, OP_RET: state_d = S_STK_WAIT;
          OP_CALL: begin
            data_d  = DATA_W'(pc_inc);
            state_d = S_STK_WAIT;
          end
          OP_HLT: state_d = S_HALT;
          default: begin
            if (opc >= OP_ALU_LO && opc <= OP_ALU_HI) state_d = S_ALU_WAIT;
          end
        endcase
      end

      S_ALU_WAIT: begin
        // acc is read live; it cannot change until our own writeback edge.
        alu_enable = 1'b1;
        alu_op     = opc;
        reg_sel    = 2'd2;
        term1      = reg_rdata;
        term2      = data_q;
        if (alu_done) begin
          reg_we    = 1'b1;
          reg_wdata = alu_out;
          state_d   = S_RETIRE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RETIRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MEM_WAIT: begin
        mem_re    = is_load;
        mem_we    = !is_load;
        mem_addr  = DATA_W'(field);
        mem_wdata = is_load ? '0 : data_q;
        reg_sel   = {1'b0, rsel};
        if (mem_done) begin
          reg_we    = is_load;
          reg_wdata = is_load ? mem_rdata : '0;
          state_d   = S_RETIRE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RETIRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STK_WAIT: begin
        push_req  = is_push_side;
        pop_req   = !is_push_side;
        push_data = is_push_side ? data_q : '0;
        reg_sel   = {1'b0, rsel};
        if (is_push_side ? push_done : pop_done) begin
          state_d = S_RETIRE;
          if (opc == OP_POP) begin
            reg_we    = 1'b1;
            reg_wdata = pop_out;
          end
          if (opc == OP_CALL) begin
            npc_d   = jmp_target;
            taken_d = 1'b1;
          end
          if (opc == OP_RET) begin
            npc_d   = pop_out[PC_W-1:0];
            taken_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RETIRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RETIRE: begin
        branch  = taken_q;
        pc_d    = npc_q;
        state_d = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      npc_q   <= '0;
      taken_q <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      taken_q <= taken_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: hand-computed PC, handshake and writeback values
// with a small register-file model behind reg_sel/reg_we.
module tb_cu_mc;
  localparam int DATA_W  = 16;
  localparam int PC_W    = 10;
  localparam int OPC_W   = 6;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 4;

  logic               clk = 1'b0;
  logic               rst_b;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               instr_ready;
  logic [PC_W-1:0]    pc_out;
  logic               fl_zero, fl_negative, fl_carry, fl_overflow;
  logic [DATA_W-1:0]  reg_rdata;
  logic [1:0]         reg_sel;
  logic               reg_we;
  logic [DATA_W-1:0]  reg_wdata;
  logic               alu_enable;
  logic [OPC_W-1:0]   alu_op;
  logic [DATA_W-1:0]  term1, term2;
  logic               alu_done;
  logic [DATA_W-1:0]  alu_out;
  logic               mem_re, mem_we;
  logic [DATA_W-1:0]  mem_addr, mem_wdata, mem_rdata;
  logic               mem_done;
  logic               push_req, pop_req;
  logic [DATA_W-1:0]  push_data;
  logic               push_done, pop_done;
  logic [DATA_W-1:0]  pop_out;
  logic               branch, halted, error;
  logic [2:0]         dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Register file model: x, y, acc with a preload port for the stimulus.
  logic [DATA_W-1:0] x_r, y_r, acc_r;
  logic              ld;
  logic [DATA_W-1:0] ld_x, ld_y, ld_acc;

  always @(posedge clk) begin
    if (ld) begin
      x_r <= ld_x; y_r <= ld_y; acc_r <= ld_acc;
    end else if (reg_we) begin
      case (reg_sel)
        2'd0: x_r <= reg_wdata;
        2'd1: y_r <= reg_wdata;
        2'd2: acc_r <= reg_wdata;
        default: ;
      endcase
    end
  end
  assign reg_rdata = (reg_sel == 2'd0) ? x_r : (reg_sel == 2'd1) ? y_r :
                     (reg_sel == 2'd2) ? acc_r : '0;

  cu_mc #(.DATA_W(DATA_W), .PC_W(PC_W), .OPC_W(OPC_W), .INSTR_W(INSTR_W),
          .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_b(rst_b), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .pc_out(pc_out),
    .fl_zero(fl_zero), .fl_negative(fl_negative), .fl_carry(fl_carry),
    .fl_overflow(fl_overflow), .reg_rdata(reg_rdata), .reg_sel(reg_sel),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .alu_enable(alu_enable),
    .alu_op(alu_op), .term1(term1), .term2(term2), .alu_done(alu_done),
    .alu_out(alu_out), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
    .push_done(push_done), .pop_done(pop_done), .pop_out(pop_out),
    .branch(branch), .halted(halted), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [5:0] opc, input logic rs,
                                             input logic [8:0] fld);
    return {opc, rs, fld};
  endfunction

  // Present one instruction in FETCH; returns one tick into DECODE.
  task automatic fetch(input logic [INSTR_W-1:0] ins);
    instruction = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic set_regs(input logic [DATA_W-1:0] xv, yv, av);
    ld_x = xv; ld_y = yv; ld_acc = av; ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  // RET whose pop returns the given PC; ends back in FETCH.
  task automatic ret_to(input logic [DATA_W-1:0] v);
    fetch(mk(6'h1B, 1'b0, 9'h000));
    step();
    pop_done = 1'b1; pop_out = v;
    step();
    pop_done = 1'b0;
    step();
  endtask

  task automatic run_simple(input logic [INSTR_W-1:0] ins);
    fetch(ins);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b1; instr_valid = 1'b0; instruction = '0;
    fl_zero = 0; fl_negative = 0; fl_carry = 0; fl_overflow = 0;
    alu_done = 0; alu_out = '0; mem_done = 0; mem_rdata = '0;
    push_done = 0; pop_done = 0; pop_out = '0;
    ld = 1'b0; ld_x = '0; ld_y = '0; ld_acc = '0;
    step(); step();
    rst_b = 1'b0;
    check("rst_ready", instr_ready, 1);
    check("rst_pc", pc_out, 0);
    check("rst_strobes", {alu_enable, mem_re, mem_we, push_req, pop_req, reg_we, branch, halted, error}, 0);

    // NOP at pc 0
    fetch(mk(6'h00, 1'b0, 9'h000));
    check("nop_decode_ready", instr_ready, 0);
    step();
    check("nop_branch", branch, 0);
    step();
    check("nop_pc", pc_out, 1);
    check("nop_ready", instr_ready, 1);

    // ADD acc + y
    set_regs(16'h0077, 16'h0003, 16'h0005);
    fetch(mk(6'h01, 1'b1, 9'h000));
    step();
    check("add_en1", alu_enable, 1);
    check("add_t1", term1, 16'h0005);
    check("add_t2", term2, 16'h0003);
    check("add_op", alu_op, 6'h01);
    check("add_we_early", reg_we, 0);
    step();
    check("add_en2", alu_enable, 1);
    alu_done = 1'b1; alu_out = 16'h0008;
    #1;
    check("add_we", reg_we, 1);
    check("add_sel", reg_sel, 2);
    check("add_wdata", reg_wdata, 16'h0008);
    step();
    alu_done = 1'b0;
    check("add_en_drop", alu_enable, 0);
    check("add_acc", acc_r, 16'h0008);
    step();
    check("add_pc", pc_out, 2);

    // JMP 5 then BRZ -2 taken / not taken
    fetch(mk(6'h17, 1'b0, 9'h005));
    step();
    check("jmp_branch", branch, 1);
    step();
    check("jmp_pc", pc_out, 5);
    fl_zero = 1'b1;
    fetch(mk(6'h12, 1'b0, 9'h1FE));
    step();
    check("brz_t_branch", branch, 1);
    step();
    check("brz_t_pc", pc_out, 3);
    run_simple(mk(6'h17, 1'b0, 9'h005));
    fl_zero = 1'b0;
    fetch(mk(6'h12, 1'b0, 9'h1FE));
    step();
    check("brz_nt_branch", branch, 0);
    step();
    check("brz_nt_pc", pc_out, 6);

    // RET to 0x3FF, CALL 0x040 (pushes wrapped pc+1), RET to 0
    fetch(mk(6'h1B, 1'b0, 9'h000));
    step();
    check("ret_popreq", pop_req, 1);
    pop_done = 1'b1; pop_out = 16'h03FF;
    step();
    pop_done = 1'b0;
    check("ret_branch", branch, 1);
    step();
    check("ret_pc", pc_out, 10'h3FF);
    fetch(mk(6'h1A, 1'b0, 9'h040));
    step();
    check("call_pushreq", push_req, 1);
    check("call_pushdata", push_data, 16'h0000);
    push_done = 1'b1;
    step();
    push_done = 1'b0;
    check("call_req_drop", push_req, 0);
    check("call_branch", branch, 1);
    step();
    check("call_pc", pc_out, 10'h040);
    fetch(mk(6'h1B, 1'b0, 9'h000));
    step();
    pop_done = 1'b1; pop_out = 16'h0000;
    step();
    pop_done = 1'b0;
    check("ret0_branch", branch, 1);
    step();
    check("ret0_pc", pc_out, 0);

    // PC wrap on NOP
    ret_to(16'h03FF);
    run_simple(mk(6'h00, 1'b0, 9'h000));
    check("wrap_pc", pc_out, 0);

    // LOAD into x, done on first wait cycle
    fetch(mk(6'h10, 1'b0, 9'h010));
    step();
    check("ld_re", mem_re, 1);
    check("ld_addr", mem_addr, 16'h0010);
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check("ld_we", reg_we, 1);
    check("ld_sel", reg_sel, 0);
    check("ld_wdata", reg_wdata, 16'hBEEF);
    step();
    mem_done = 1'b0;
    check("ld_x", x_r, 16'hBEEF);
    step();
    check("ld_pc", pc_out, 1);

    // STORE y
    fetch(mk(6'h11, 1'b1, 9'h022));
    step();
    check("st_we", mem_we, 1);
    check("st_wdata", mem_wdata, 16'h0003);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    step();
    check("st_pc", pc_out, 2);

    // ALU done exactly at the timeout limit wins
    fetch(mk(6'h02, 1'b0, 9'h000));
    step(); step(); step(); step();
    check("lim_en", alu_enable, 1);
    alu_done = 1'b1; alu_out = 16'h1234;
    #1;
    check("lim_we", reg_we, 1);
    step();
    alu_done = 1'b0;
    check("lim_err", error, 0);
    check("lim_acc", acc_r, 16'h1234);
    step();
    check("lim_pc", pc_out, 3);

    // LOAD timeout: request held 4 cycles, error, no writeback, pc+1
    fetch(mk(6'h10, 1'b1, 9'h023));
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      check($sformatf("to_re_%0d", i), mem_re, 1);
      check($sformatf("to_we_%0d", i), reg_we, 0);
    end
    step();
    check("to_re_drop", mem_re, 0);
    check("to_err", error, 1);
    check("to_branch", branch, 0);
    check("to_y", y_r, 16'h0003);
    step();
    check("to_pc", pc_out, 4);

    // Reset mid ALU_WAIT
    fetch(mk(6'h01, 1'b0, 9'h000));
    step();
    check("mid_en", alu_enable, 1);
    rst_b = 1'b1;
    step();
    check("mid_en_drop", alu_enable, 0);
    check("mid_pc", pc_out, 0);
    check("mid_halt", halted, 0);
    check("mid_err", error, 0);
    rst_b = 1'b0;

    // HLT: frozen until reset
    run_simple(mk(6'h00, 1'b0, 9'h000));
    fetch(mk(6'h3F, 1'b0, 9'h000));
    step();
    check("hlt_halted", halted, 1);
    instr_valid = 1'b1; instruction = '0;
    step(); step(); step();
    check("hlt_still", halted, 1);
    check("hlt_ready", instr_ready, 0);
    check("hlt_pc", pc_out, 1);
    instr_valid = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check("hlt_rst_halted", halted, 0);
    check("hlt_rst_pc", pc_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
